// File: rtl/microcode_sequencer_if.sv
// Driver/ROM-facing bundle of the microcode sequencer:
// opcode and sequencing controls in, ROM address and decoded controls out.
interface microcode_sequencer_if #(
  parameter int OPCODE_WIDTH  = 4,
  parameter int STEP_WIDTH    = 3,
  parameter int CONTROL_WIDTH = 16
);
  logic [OPCODE_WIDTH-1:0]            opcode;
  logic                               microcode_sequencer_load_n;
  logic                               microcode_sequencer_enable;
  logic                               microcode_rom_read_enable;
  logic [OPCODE_WIDTH+STEP_WIDTH-1:0] rom_address;
  logic [CONTROL_WIDTH-1:0]           rom_data;
  logic [CONTROL_WIDTH-1:0]           control_word;
  logic                               instruction_finish_control_line;
  logic                               halt;
  logic                               jump_flag;
  logic                               microcode_overrun;
  logic [STEP_WIDTH-1:0]              step;

  modport master (
    output opcode,
    output microcode_sequencer_load_n,
    output microcode_sequencer_enable,
    output microcode_rom_read_enable,
    output rom_data,
    input  rom_address,
    input  control_word,
    input  instruction_finish_control_line,
    input  halt,
    input  jump_flag,
    input  microcode_overrun,
    input  step
  );

  modport slave (
    input  opcode,
    input  microcode_sequencer_load_n,
    input  microcode_sequencer_enable,
    input  microcode_rom_read_enable,
    input  rom_data,
    output rom_address,
    output control_word,
    output instruction_finish_control_line,
    output halt,
    output jump_flag,
    output microcode_overrun,
    output step
  );
endinterface

// File: rtl/microcode_sequencer.sv
// Microcode address sequencer: latches {opcode, step}, walks ROM words,
// and decodes finish / halt / jump control bits back to the driver.
module microcode_sequencer #(
  parameter int OPCODE_WIDTH  = 4,
  parameter int STEP_WIDTH    = 3,
  parameter int CONTROL_WIDTH = 16,
  parameter int FINISH_BIT    = 0,
  parameter int HALT_BIT      = 1,
  parameter int JUMP_BIT      = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  microcode_sequencer_if.slave bus
);

  localparam logic [STEP_WIDTH-1:0] STEP_MAX = '1;

  logic [OPCODE_WIDTH-1:0]  opcode_q, opcode_d;
  logic [STEP_WIDTH-1:0]    step_q, step_d;
  logic                     halted_q, halted_d;
  logic                     jump_taken_q, jump_taken_d;
  logic                     jump_flag_q, jump_flag_d;
  logic                     overrun_q, overrun_d;
  logic [CONTROL_WIDTH-1:0] cw;
  logic                     finish;

  assign cw = (bus.microcode_rom_read_enable && !halted_q)
            ? bus.rom_data : '0;
  assign finish = cw[FINISH_BIT] | overrun_q;

  assign bus.rom_address                     = {opcode_q, step_q};
  assign bus.control_word                    = cw;
  assign bus.instruction_finish_control_line = finish;
  assign bus.halt                            = halted_q;
  assign bus.jump_flag                       = jump_flag_q;
  assign bus.microcode_overrun               = overrun_q;
  assign bus.step                            = step_q;

  always_comb begin
    opcode_d     = opcode_q;
    step_d       = step_q;
    jump_taken_d = jump_taken_q;
    overrun_d    = overrun_q;
    // cw is forced to zero while halted, so no new halt/jump can arise
    halted_d     = halted_q | cw[HALT_BIT];
    jump_flag_d  = cw[JUMP_BIT] & ~jump_taken_q;
    if (!halted_q) begin
      if (jump_flag_d)
        jump_taken_d = 1'b1;
      if (!bus.microcode_sequencer_load_n) begin
        opcode_d     = bus.opcode;
        step_d       = '0;
        jump_taken_d = 1'b0;
        overrun_d    = 1'b0;
      end else if (bus.microcode_sequencer_enable && !finish) begin
        if (step_q == STEP_MAX)
          overrun_d = 1'b1;
        else
          step_d = step_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      opcode_q     <= '0;
      step_q       <= '0;
      halted_q     <= 1'b0;
      jump_taken_q <= 1'b0;
      jump_flag_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      opcode_q     <= opcode_d;
      step_q       <= step_d;
      halted_q     <= halted_d;
      jump_taken_q <= jump_taken_d;
      jump_flag_q  <= jump_flag_d;
      overrun_q    <= overrun_d;
    end
  end

endmodule

// File: tb/tb_microcode_sequencer.sv
// Bench for microcode_sequencer: directed scenarios plus random traffic
// compared every cycle against a behavioural sequencer model.
module tb_microcode_sequencer;

  localparam int OW = 4;
  localparam int SW = 3;
  localparam int CW = 16;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  microcode_sequencer_if #(
    .OPCODE_WIDTH(OW), .STEP_WIDTH(SW), .CONTROL_WIDTH(CW)
  ) bus ();

  microcode_sequencer #(
    .OPCODE_WIDTH(OW), .STEP_WIDTH(SW), .CONTROL_WIDTH(CW),
    .FINISH_BIT(0), .HALT_BIT(1), .JUMP_BIT(2)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus.slave)
  );

  logic [15:0] rom [128];
  assign bus.rom_data = rom[bus.rom_address];

  int n_cmp = 0;
  int n_mis = 0;
  bit chk_en = 0;

  int m_op   = 0;
  int m_step = 0;
  bit m_halt = 0;
  bit m_jt   = 0;
  bit m_jf   = 0;
  bit m_ovr  = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] model_cw();
    if (bus.microcode_rom_read_enable && !m_halt)
      return rom[m_op * 8 + m_step];
    return 16'h0;
  endfunction

  task automatic model_update();
    logic [15:0] w;
    bit fin;
    bit jf_n;
    w    = model_cw();
    fin  = w[0] | m_ovr;
    jf_n = w[2] && !m_jt;
    if (reset) begin
      m_op = 0; m_step = 0; m_halt = 0;
      m_jt = 0; m_jf = 0; m_ovr = 0;
    end else begin
      if (!m_halt) begin
        if (jf_n) m_jt = 1;
        if (!bus.microcode_sequencer_load_n) begin
          m_op = int'(bus.opcode); m_step = 0; m_jt = 0; m_ovr = 0;
        end else if (bus.microcode_sequencer_enable && !fin) begin
          if (m_step == 7) m_ovr = 1;
          else m_step = m_step + 1;
        end
      end
      if (w[1]) m_halt = 1;
      m_jf = jf_n;
    end
  endtask

  task automatic compare_all();
    logic [15:0] w;
    w = model_cw();
    chk("m_rom_address", 32'(bus.rom_address), 32'(m_op * 8 + m_step));
    chk("m_control_word", 32'(bus.control_word), 32'(w));
    chk("m_finish", 32'(bus.instruction_finish_control_line),
        32'(w[0] | m_ovr));
    chk("m_halt", 32'(bus.halt), 32'(m_halt));
    chk("m_jump_flag", 32'(bus.jump_flag), 32'(m_jf));
    chk("m_overrun", 32'(bus.microcode_overrun), 32'(m_ovr));
    chk("m_step", 32'(bus.step), 32'(m_step));
  endtask

  initial begin
    forever begin
      @(negedge clock);
      if (chk_en) compare_all();
    end
  end

  task automatic tick(bit rst, bit ld_n, bit en, bit re, int opc);
    #1;
    reset = rst;
    bus.microcode_sequencer_load_n = ld_n;
    bus.microcode_sequencer_enable = en;
    bus.microcode_rom_read_enable = re;
    bus.opcode = OW'(opc);
    @(posedge clock);
    model_update();
    @(negedge clock);
  endtask

  task automatic fill_rom_random();
    logic [15:0] w;
    #1;
    for (int i = 0; i < 128; i++) begin
      w = 16'($urandom);
      w[1] = ($urandom % 16 == 0);
      w[0] = ($urandom % 3 == 0);
      rom[i] = w;
    end
  endtask

  initial begin
    for (int i = 0; i < 128; i++) rom[i] = 16'h0;
    bus.opcode = '0;
    bus.microcode_sequencer_load_n = 1'b1;
    bus.microcode_sequencer_enable = 1'b0;
    bus.microcode_rom_read_enable = 1'b1;

    tick(1, 1, 0, 1, 0);
    tick(1, 1, 0, 1, 0);
    chk_en = 1;
    chk("rst_step", 32'(bus.step), 0);
    chk("rst_addr", 32'(bus.rom_address), 0);
    chk("rst_halt", 32'(bus.halt), 0);
    chk("rst_jump", 32'(bus.jump_flag), 0);
    chk("rst_ovr", 32'(bus.microcode_overrun), 0);
    chk("rst_fin", 32'(bus.instruction_finish_control_line), 0);

    // single-step instruction: finish on step 0
    rom[24] = 16'h0001;
    tick(0, 0, 0, 1, 3);
    chk("t1_addr", 32'(bus.rom_address), 32'h18);
    chk("t1_fin", 32'(bus.instruction_finish_control_line), 1);
    tick(0, 1, 1, 1, 0);
    chk("t1_step_hold", 32'(bus.step), 0);
    chk("t1_fin_hold", 32'(bus.instruction_finish_control_line), 1);

    // three-step instruction
    rom[40] = 16'h0010; rom[41] = 16'h0020; rom[42] = 16'h0021;
    tick(0, 0, 1, 1, 5);
    chk("t2_cw0", 32'(bus.control_word), 32'h10);
    chk("t2_fin0", 32'(bus.instruction_finish_control_line), 0);
    tick(0, 1, 1, 1, 0);
    chk("t2_cw1", 32'(bus.control_word), 32'h20);
    chk("t2_fin1", 32'(bus.instruction_finish_control_line), 0);
    tick(0, 1, 1, 1, 0);
    chk("t2_cw2", 32'(bus.control_word), 32'h21);
    chk("t2_fin2", 32'(bus.instruction_finish_control_line), 1);
    tick(0, 1, 1, 1, 0);
    chk("t2_step_hold", 32'(bus.step), 2);

    // jump pulse once per loaded instruction
    rom[17] = 16'h0004;
    for (int r = 0; r < 2; r++) begin
      tick(0, 0, 0, 1, 2);
      chk("t3_jf_load", 32'(bus.jump_flag), 0);
      tick(0, 1, 1, 1, 0);
      chk("t3_cw", 32'(bus.control_word), 32'h4);
      chk("t3_jf_pre", 32'(bus.jump_flag), 0);
      tick(0, 1, 0, 1, 0);
      chk("t3_jf_pulse", 32'(bus.jump_flag), 1);
      tick(0, 1, 0, 1, 0);
      chk("t3_jf_clear", 32'(bus.jump_flag), 0);
    end

    // halt freezes state until reset
    rom[56] = 16'h0002;
    tick(0, 0, 0, 1, 7);
    chk("t4_cw", 32'(bus.control_word), 32'h2);
    chk("t4_halt_pre", 32'(bus.halt), 0);
    tick(0, 1, 0, 1, 0);
    chk("t4_halt", 32'(bus.halt), 1);
    chk("t4_cw_zero", 32'(bus.control_word), 0);
    tick(0, 0, 1, 1, 3);
    chk("t4_addr_frozen", 32'(bus.rom_address), 32'h38);
    chk("t4_halt_sticky", 32'(bus.halt), 1);
    tick(1, 1, 0, 1, 0);
    chk("t4_halt_reset", 32'(bus.halt), 0);

    // overrun after exhausting all steps
    tick(0, 0, 0, 1, 1);
    for (int s = 1; s <= 7; s++) begin
      tick(0, 1, 1, 1, 0);
      chk("t5_step", 32'(bus.step), 32'(s));
    end
    chk("t5_ovr_pre", 32'(bus.microcode_overrun), 0);
    tick(0, 1, 1, 1, 0);
    chk("t5_ovr", 32'(bus.microcode_overrun), 1);
    chk("t5_fin", 32'(bus.instruction_finish_control_line), 1);
    chk("t5_step7", 32'(bus.step), 7);
    tick(0, 0, 0, 1, 3);
    chk("t5_ovr_clear", 32'(bus.microcode_overrun), 0);

    // load beats enable; reset aborts mid-instruction
    tick(0, 0, 0, 1, 4);
    for (int s = 0; s < 4; s++) tick(0, 1, 1, 1, 0);
    chk("t6_step4", 32'(bus.step), 4);
    tick(0, 0, 1, 1, 6);
    chk("t6_step0", 32'(bus.step), 0);
    chk("t6_addr", 32'(bus.rom_address), 32'h30);
    for (int s = 0; s < 3; s++) tick(0, 1, 1, 1, 0);
    chk("t6_step3", 32'(bus.step), 3);
    tick(1, 1, 1, 1, 0);
    chk("t6_rst_step", 32'(bus.step), 0);
    chk("t6_rst_addr", 32'(bus.rom_address), 0);
    chk("t6_rst_fin", 32'(bus.instruction_finish_control_line), 0);

    // random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      if (i % 250 == 0) fill_rom_random();
      tick(($urandom % 40) == 0,
           ($urandom % 6) != 0,
           ($urandom % 4) != 0,
           ($urandom % 8) != 0,
           int'($urandom % 16));
    end

    #1;
    chk_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
